// File: rtl/cabac_de_parse_mvd.sv
// cabac_de_parse_mvd: decodes one mvd_coding set (x, y) plus mvp_lx_flag
// by requesting CABAC bins one at a time, context-coded or bypass.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i             begin one parse (honoured only when idle)
//   bin_req_o/ctx/byp   registered bin request towards the bin decoder
//   bin_vld_i, bin_i    decoded bin; consumed when bin_req_o && bin_vld_i
//   mvd_o               {mvd_x, mvd_y}, two's complement, held until next parse
//   mvp_idx_o           mvp_lx_flag zero-extended
//   done_o, err_o       one-cycle completion / EG1 prefix overflow pulses
//   busy_o              high whenever not idle
module cabac_de_parse_mvd #(
    parameter int MVD_WIDTH     = 11,
    parameter int EG_MAX_PREFIX = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    output logic                   bin_req_o,
    output logic [8:0]             bin_ctx_o,
    output logic                   bin_bypass_o,
    input  logic                   bin_vld_i,
    input  logic                   bin_i,
    output logic [2*MVD_WIDTH-1:0] mvd_o,
    output logic [2:0]             mvp_idx_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   busy_o
);
    localparam int KW = $clog2(EG_MAX_PREFIX + 2);
    localparam logic [KW-1:0] K_MAX = KW'(EG_MAX_PREFIX + 1);
    localparam logic [MVD_WIDTH-1:0] ONE = MVD_WIDTH'(1);

    typedef enum logic [3:0] {
        IDLE, G0X, G0Y, G1X, G1Y,
        EGX_PRE, EGX_SUF, SGNX,
        EGY_PRE, EGY_SUF, SGNY,
        MVP, DONE
    } state_e;

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic [8:0]             ctx_q, ctx_d;
    logic                   byp_q, byp_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   g0x_q, g0x_d, g0y_q, g0y_d;
    logic                   g1x_q, g1x_d, g1y_q, g1y_d;
    logic                   sgnx_q, sgnx_d, sgny_q, sgny_d;
    logic [MVD_WIDTH-1:0]   absx_q, absx_d, absy_q, absy_d;
    logic [MVD_WIDTH-1:0]   acc_q, acc_d;
    logic [KW-1:0]          k_q, k_d, rem_q, rem_d;
    logic [2*MVD_WIDTH-1:0] mvd_q, mvd_d;
    logic                   mvp_q, mvp_d;

    logic                   take;
    logic [MVD_WIDTH-1:0]   acc_pre, acc_suf, cmp_x, cmp_y;

    assign take    = req_q & bin_vld_i;
    assign acc_pre = acc_q + (ONE << k_q);
    assign acc_suf = acc_q + (MVD_WIDTH'(bin_i) << (rem_q - KW'(1)));
    assign cmp_x   = sgnx_q ? (~absx_q + ONE) : absx_q;
    assign cmp_y   = sgny_q ? (~absy_q + ONE) : absy_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        g0x_d   = g0x_q;
        g0y_d   = g0y_q;
        g1x_d   = g1x_q;
        g1y_d   = g1y_q;
        sgnx_d  = sgnx_q;
        sgny_d  = sgny_q;
        absx_d  = absx_q;
        absy_d  = absy_q;
        acc_d   = acc_q;
        k_d     = k_q;
        rem_d   = rem_q;
        mvd_d   = mvd_q;
        mvp_d   = mvp_q;
        unique case (state_q)
            IDLE: if (start_i) begin
                state_d = G0X;
                {g0x_d, g0y_d, g1x_d, g1y_d} = '0;
                {sgnx_d, sgny_d} = '0;
                absx_d = '0;
                absy_d = '0;
            end
            G0X: if (take) begin
                g0x_d   = bin_i;
                absx_d  = MVD_WIDTH'(bin_i);
                state_d = G0Y;
            end
            G0Y: if (take) begin
                g0y_d  = bin_i;
                absy_d = MVD_WIDTH'(bin_i);
                if (g0x_q)      state_d = G1X;
                else if (bin_i) state_d = G1Y;
                else            state_d = MVP;
            end
            G1X: if (take) begin
                g1x_d = bin_i;
                if (g0y_q)      state_d = G1Y;
                else if (bin_i) state_d = EGX_PRE;
                else            state_d = SGNX;
            end
            G1Y: if (take) begin
                g1y_d = bin_i;
                if (g1x_q)      state_d = EGX_PRE;
                else if (g0x_q) state_d = SGNX;
                else if (bin_i) state_d = EGY_PRE;
                else            state_d = SGNY;
            end
            EGX_PRE, EGY_PRE: if (take) begin
                if (!bin_i) begin
                    rem_d   = k_q;
                    state_d = (state_q == EGX_PRE) ? EGX_SUF : EGY_SUF;
                end else if (k_q == K_MAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    acc_d = acc_pre;
                    k_d   = k_q + KW'(1);
                end
            end
            EGX_SUF, EGY_SUF: if (take) begin
                acc_d = acc_suf;
                rem_d = rem_q - KW'(1);
                if (rem_q == KW'(1)) begin
                    if (state_q == EGX_SUF) begin
                        absx_d  = acc_suf + MVD_WIDTH'(2);
                        state_d = SGNX;
                    end else begin
                        absy_d  = acc_suf + MVD_WIDTH'(2);
                        state_d = SGNY;
                    end
                end
            end
            SGNX: if (take) begin
                sgnx_d = bin_i;
                if (g1y_q)      state_d = EGY_PRE;
                else if (g0y_q) state_d = SGNY;
                else            state_d = MVP;
            end
            SGNY: if (take) begin
                sgny_d  = bin_i;
                state_d = MVP;
            end
            MVP: if (take) begin
                mvd_d   = {cmp_x, cmp_y};
                mvp_d   = bin_i;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Fresh EG1 accumulator whenever a prefix is entered.
        if ((state_d == EGX_PRE || state_d == EGY_PRE) && state_d != state_q) begin
            k_d   = KW'(1);
            acc_d = '0;
        end
    end

    // Request fields are registered from the next state so they are
    // stable for as long as the bin is stalled.
    always_comb begin
        req_d = 1'b1;
        ctx_d = 9'h000;
        byp_d = 1'b0;
        unique case (state_d)
            G0X, G0Y: ctx_d = 9'h016;
            G1X, G1Y: ctx_d = 9'h017;
            MVP:      ctx_d = 9'h0b0;
            EGX_PRE, EGX_SUF, SGNX,
            EGY_PRE, EGY_SUF, SGNY: byp_d = 1'b1;
            default:  req_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            ctx_q   <= '0;
            byp_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            g0x_q   <= 1'b0;
            g0y_q   <= 1'b0;
            g1x_q   <= 1'b0;
            g1y_q   <= 1'b0;
            sgnx_q  <= 1'b0;
            sgny_q  <= 1'b0;
            absx_q  <= '0;
            absy_q  <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            rem_q   <= '0;
            mvd_q   <= '0;
            mvp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ctx_q   <= ctx_d;
            byp_q   <= byp_d;
            done_q  <= done_d;
            err_q   <= err_d;
            g0x_q   <= g0x_d;
            g0y_q   <= g0y_d;
            g1x_q   <= g1x_d;
            g1y_q   <= g1y_d;
            sgnx_q  <= sgnx_d;
            sgny_q  <= sgny_d;
            absx_q  <= absx_d;
            absy_q  <= absy_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            rem_q   <= rem_d;
            mvd_q   <= mvd_d;
            mvp_q   <= mvp_d;
        end
    end

    assign bin_req_o    = req_q;
    assign bin_ctx_o    = ctx_q;
    assign bin_bypass_o = byp_q;
    assign mvd_o        = mvd_q;
    assign mvp_idx_o    = {2'b00, mvp_q};
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign busy_o       = (state_q != IDLE);
endmodule
